audio_i2s_tx: RTL
=================

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per bclk half-period; legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: sample FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk  in  1: single clock; every register SHALL be on its rising edge.
REQ-004 SHALL have port rst_n  in  1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  in  1: one-cycle sample strobe, driven by the low-pass filter's enable pulse.
REQ-006 SHALL have port in_data  in  8: signed Q1.7 sample, taken from the low-pass filter y_out.
REQ-007 SHALL have port in_ready  out  1: high when the FIFO is not full.
REQ-008 SHALL have ports bclk, lrclk and sdata  out  1 each: serial DAC bus; lrclk 0 = left slot, 1 = right slot.
REQ-009 SHALL have ports overflow and underrun  out  1 each: sticky error flags.

Function
REQ-010 SHALL accept a push only when in_valid=1 and in_ready=1.
REQ-011 SHALL drop the sample and set overflow when in_valid=1 and the FIFO is full, even if a pop occurs in the same cycle.
REQ-012 SHALL leave the FIFO count unchanged on a simultaneous push and pop (FIFO neither full nor empty).
REQ-013 SHALL implement FSM states IDLE, LEFT and RIGHT.
- IDLE: bclk=0, lrclk=0, sdata=0.
- IDLE->LEFT: on the first clk cycle where the FIFO is non-empty.
REQ-014 SHALL, on entry to LEFT from IDLE or RIGHT:
- pop one sample S;
- load the 16-bit shift register with {S, 8'h00};
- set lrclk=0;
- drive sdata with bit 15 in the same registered update.
REQ-015 SHALL, in LEFT/RIGHT, toggle bclk every CLK_DIV clk cycles.
- Data and lrclk change only on bclk falling transitions; the DAC samples on rising edges.
- Each falling transition shifts the register left by 1.
REQ-016 SHALL, after 16 bclk falling transitions in LEFT, go to RIGHT: reload {S, 8'h00} (mono duplicate), set lrclk=1.
- After 16 more falling transitions, go to LEFT.
- Frame = 32 bclk periods = 64*CLK_DIV clk cycles.
REQ-017 SHALL, at LEFT entry with the FIFO empty, transmit S=0 for both slots and set underrun; the FSM SHALL NOT return to IDLE.
REQ-018 SHALL sign-preserve: 8'h80 is sent as 16'h8000 and 8'h7F as 16'h7F00, MSB first.

Reset
REQ-019 SHALL, while rst_n=0, force:
- state=IDLE; FIFO empty; in_ready=1;
- bclk, lrclk, sdata, overflow and underrun = 0;
- bclk divider counter and bit counter = 0.
REQ-020 SHALL, on reset mid-frame, abort the frame immediately, discard FIFO contents, and hold bclk low (no glitch) until the next IDLE->LEFT.

Configuration
REQ-021 SHALL honour macro AUDIO_TX_MUTE_EN.
- Defined: add input port mute (1 bit), sampled at LEFT entry; if 1, the frame sends zeros but still pops the FIFO.
- Undefined: no mute port; frames are never muted.

Structure
REQ-022 SHALL take from shared package audio_pkg:
- typedef sample_t (logic signed [7:0]);
- enum tx_state_t {IDLE, LEFT, RIGHT};
- localparam SLOT_BITS=16.
REQ-023 SHALL contain exactly one sub-module, audio_sample_fifo: synchronous FIFO of sample_t with full/empty flags, parameterised by FIFO_DEPTH.

Verification
REQ-024 Single sample: push 8'h40 from IDLE, CLK_DIV=4 -> lrclk=0; sdata carries 0100_0000_0000_0000 over 16 bclk periods; the same word repeats with lrclk=1.
REQ-025 Negative full scale: push 8'h80 -> each slot sends 16'h8000; no flags set.
REQ-026 Overflow: push 5 samples back-to-back at FIFO_DEPTH=4 before any pop -> in_ready=0 after the 4th push; 5th push dropped; overflow=1; samples 1-4 come out in order.
REQ-027 Underrun: push one sample, wait 2 frames -> frame 2 sends all zeros; underrun=1; lrclk keeps toggling every 16 bclk periods.
REQ-028 Reset mid-frame: assert rst_n=0 at bit 7 of LEFT -> all outputs 0 asynchronously; after release, IDLE until the next push.
REQ-029 Mute (AUDIO_TX_MUTE_EN defined): mute=1 with 8'h7F queued -> frame sends zeros; FIFO count decrements by 1.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types for the audio I2S transmit path: sample format, FSM states,
// slot width and the sample-to-slot-word mapping.
package audio_pkg;

  typedef logic signed [7:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } tx_state_t;

  localparam int SLOT_BITS = 16;

  // Left-justify the Q1.7 sample in a slot; the sign bit lands in the MSB.
  function automatic logic [SLOT_BITS-1:0] slot_word(input sample_t s);
    return {s, 8'h00};
  endfunction

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Sample stream into the I2S transmitter: one-cycle strobe plus ready.
interface audio_i2s_tx_if;
  import audio_pkg::*;

  logic    in_valid;
  sample_t in_data;
  logic    in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/audio_sample_fifo.sv
// Small synchronous sample FIFO with full/empty flags. Read data is
// show-ahead (head entry always visible) so the transmitter can pop and
// load its shift register in the same clock.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    wr_en,
  input  sample_t wr_data,
  input  logic    rd_en,
  output sample_t rd_data,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  sample_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_wr, do_rd;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr_reg];

  // Storage array: written only, never reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// Mono-to-stereo I2S transmitter: buffers 8-bit samples and sends each one
// left-justified in a 16-bit left slot and again in the right slot.
// Optional feature macro: AUDIO_TX_MUTE_EN adds a mute input sampled at
// each left-slot start.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  audio_i2s_tx_if.slave        in_if,
`ifdef AUDIO_TX_MUTE_EN
  input  logic                 mute,
`endif
  output logic                 bclk,
  output logic                 lrclk,
  output logic                 sdata,
  output logic                 overflow,
  output logic                 underrun
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  tx_state_t            state_reg, state_next;
  logic [7:0]           div_cnt_reg;
  logic [3:0]           bit_cnt_reg;
  logic [SLOT_BITS-1:0] shift_reg;
  logic                 bclk_reg, lrclk_reg;
  sample_t              sample_reg;
  logic                 overflow_reg, underrun_reg;

  logic    fifo_full, fifo_empty, fifo_pop, fifo_push;
  sample_t fifo_rd_data;
  logic    half_tick, fall, slot_end, left_entry, mute_now;
  sample_t new_sample;

`ifdef AUDIO_TX_MUTE_EN
  assign mute_now = mute;
`else
  assign mute_now = 1'b0;
`endif

  assign in_if.in_ready = ~fifo_full;
  assign fifo_push      = in_if.in_valid & ~fifo_full;

  // A bclk falling transition is a half-period tick while bclk is high.
  assign half_tick = (state_reg != IDLE) && (div_cnt_reg == DIV_LAST);
  assign fall      = half_tick & bclk_reg;
  assign slot_end  = fall && (bit_cnt_reg == 4'd15);

  audio_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_push),
    .wr_data (in_if.in_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state: slots alternate forever once started; only reset reaches IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!fifo_empty) state_next = LEFT;
      LEFT:    if (slot_end)    state_next = RIGHT;
      RIGHT:   if (slot_end)    state_next = LEFT;
      default: state_next = IDLE;
    endcase
  end

  // Outputs and frame-start controls: pop at every left-slot start, zeros when muted or starved.
  always_comb begin
    left_entry = ((state_reg == IDLE) && !fifo_empty) ||
                 ((state_reg == RIGHT) && slot_end);
    fifo_pop   = left_entry && !fifo_empty;
    new_sample = (fifo_empty || mute_now) ? sample_t'(0) : fifo_rd_data;
    bclk       = bclk_reg;
    lrclk      = lrclk_reg;
    sdata      = shift_reg[SLOT_BITS-1];
    overflow   = overflow_reg;
    underrun   = underrun_reg;
  end

  // Serialiser: bclk divider, bit counter and shift register; data moves on falling bclk only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      bclk_reg    <= 1'b0;
      lrclk_reg   <= 1'b0;
      sample_reg  <= '0;
    end else if (left_entry) begin
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
      lrclk_reg   <= 1'b0;
      sample_reg  <= new_sample;
      shift_reg   <= slot_word(new_sample);
    end else if (state_reg != IDLE) begin
      if (half_tick) begin
        div_cnt_reg <= '0;
        bclk_reg    <= ~bclk_reg;
      end else begin
        div_cnt_reg <= div_cnt_reg + 8'd1;
      end
      if (fall) begin
        if (bit_cnt_reg == 4'd15) begin
          // End of left slot: repeat the same sample on the right.
          bit_cnt_reg <= '0;
          lrclk_reg   <= 1'b1;
          shift_reg   <= slot_word(sample_reg);
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
          shift_reg   <= {shift_reg[SLOT_BITS-2:0], 1'b0};
        end
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      if (in_if.in_valid && fifo_full)                     overflow_reg <= 1'b1;
      if ((state_reg == RIGHT) && slot_end && fifo_empty) underrun_reg <= 1'b1;
    end
  end

endmodule
